// File: rtl/clkmon_pkg.sv
// clkmon_pkg: shared state encodings and sizing helper for the slow-clock monitor
package clkmon_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } state_t;

  // Counter must reach the timeout value EXP_PERIOD+TOL+1 without saturating first.
  function automatic int cnt_width(input int exp_period, input int tol);
    return $clog2(exp_period + tol + 2);
  endfunction
endpackage

// File: rtl/clkmon_sync_edge.sv
// clkmon_sync_edge: synchroniser chain for an async level with registered rise/fall strobes
module clkmon_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] s;
  logic s_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s    <= '0;
      s_d  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s    <= {s[STAGES-2:0], d};
      s_d  <= s[STAGES-1];
      rise <= s[STAGES-1] & ~s_d;
      fall <= ~s[STAGES-1] & s_d;
    end
endmodule

// File: rtl/clkmon.sv
// clkmon: slow-clock monitor with edge strobes, period measurement and lock/loss tracking
module clkmon
  import clkmon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EXP_PERIOD  = 8,
  parameter int TOL         = 1,
  parameter int LOCK_CNT    = 4,
  localparam int CNT_W      = cnt_width(EXP_PERIOD, TOL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             clr,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             lost
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TMO_AT = CNT_W'(EXP_PERIOD + TOL + 1);
  localparam logic [GW-1:0]    G_LAST = GW'(LOCK_CNT - 1);
  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0] g, g_nxt;
  logic in_win, tmo, meas, enter_lost;
  clkmon_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sclk),
    .rise (rise),
    .fall (fall)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (rise) cnt <= CNT_W'(1);
    else if (~&cnt) cnt <= cnt + 1'b1;
  assign in_win = (cnt >= WIN_LO) && (cnt <= WIN_HI);
  assign tmo    = (cnt == TMO_AT) && !rise;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= ST_IDLE;
      g  <= '0;
    end else begin
      st <= nxt;
      g  <= g_nxt;
    end
  always_comb begin
    nxt   = st;
    g_nxt = g;
    case (st)
      ST_IDLE, ST_LOST:
        if (rise) begin
          nxt   = ST_ACQ;
          g_nxt = '0;
        end
      ST_ACQ:
        if (rise && in_win) begin
          g_nxt = g + 1'b1;
          nxt   = (g == G_LAST) ? ST_LOCKED : ST_ACQ;
        end else if (rise) g_nxt = '0;
        else if (tmo) nxt = ST_LOST;
      ST_LOCKED:
        nxt = ((rise && !in_win) || tmo) ? ST_LOST : ST_LOCKED;
    endcase
  end
  always_comb begin
    locked     = (st == ST_LOCKED);
    meas       = rise && (st == ST_ACQ || st == ST_LOCKED);
    enter_lost = (nxt == ST_LOST) && (st != ST_LOST);
  end
  // A new loss outranks a simultaneous clear so no loss event is ever dropped.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      period     <= '0;
      period_vld <= 1'b0;
      lost       <= 1'b0;
    end else begin
      period_vld <= meas;
      if (meas) period <= cnt;
      lost <= enter_lost | (lost & ~clr);
    end
endmodule

// File: tb/tb_clkmon.sv
// tb_clkmon: randomized scoreboard bench for clkmon against an event-level reference model
module tb_clkmon;
  localparam int EXP = 8, TOL = 1, LCK = 4, CW = 4, MAXL = 256, LIM = EXP + TOL + 1;
  localparam int K_RISE = 0, K_FALL = 1, K_PER = 2, K_LOCK = 3, K_LOST = 4, K_RISE3 = 5, K_PER3 = 6;
  typedef struct {int t; int v;} ev_t;
  logic clk = 0, rst_n = 0, sclk = 0, clr = 0;
  logic rise, fall, period_vld, locked, lost;
  logic rise3, fall3, pv3, locked3, lost3;
  logic [CW-1:0] period, period3;
  int cyc = 0, n_cmp = 0, n_bad = 0, t0 = 0, cur_len = 0, tpl = 0, exp_lock = 0, exp_lost = 0;
  bit mon_en = 0;
  logic prev_lock = 0, prev_lost = 0;
  bit lvl[MAXL];
  bit clrs[MAXL];
  int plan[$];
  ev_t q[7][$];
  string names[7] = '{"rise", "fall", "period", "locked", "lost", "rise_s3", "period_s3"};

  clkmon dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .clr(clr), .rise(rise), .fall(fall),
    .period(period), .period_vld(period_vld), .locked(locked), .lost(lost)
  );
  clkmon #(.SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .clr(clr), .rise(rise3), .fall(fall3),
    .period(period3), .period_vld(pv3), .locked(locked3), .lost(lost3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void push(input int k, input int rel, input int v);
    if (rel < cur_len) begin
      q[k].push_back('{t0 + rel, v});
      if (k == K_LOCK) exp_lock = v;
      if (k == K_LOST) exp_lost = v;
    end
  endfunction

  task automatic chk(input int k, input logic hit, input int val);
    ev_t e;
    if (hit) begin
      n_cmp++;
      if (q[k].size() == 0) begin
        n_bad++;
        $display("FAIL %s: event at cycle %0d value %0d, required no event", names[k], cyc, val);
      end else begin
        e = q[k].pop_front();
        if (e.t != cyc || e.v != val) begin
          n_bad++;
          $display("FAIL %s: cycle %0d value %0d, required cycle %0d value %0d", names[k], cyc, val, e.t, e.v);
        end
      end
    end else if (q[k].size() != 0 && q[k][0].t <= cyc) begin
      n_cmp++;
      n_bad++;
      e = q[k].pop_front();
      $display("FAIL %s: no event by cycle %0d, required cycle %0d value %0d", names[k], cyc, e.t, e.v);
    end
  endtask

  always @(negedge clk)
    if (mon_en) begin
      chk(K_RISE, rise, 1);
      chk(K_FALL, fall, 1);
      chk(K_PER, period_vld, int'(period));
      chk(K_LOCK, locked != prev_lock, int'(locked));
      chk(K_LOST, lost != prev_lost, int'(lost));
      chk(K_RISE3, rise3, 1);
      chk(K_PER3, pv3, int'(period3));
      prev_lock = locked;
      prev_lost = lost;
    end

  // Reference: walk the rise times, applying the window, timeout and lock rules per period.
  task automatic model();
    int rs[$];
    bit setv[MAXL];
    int st, g, last, nxt, gap, l, nl;
    bit ok, pv;
    st = 0; g = 0; last = 0; l = 0;
    exp_lock = 0; exp_lost = 0;
    for (int i = 0; i < MAXL; i++) setv[i] = 0;
    for (int i = 0; i < cur_len; i++) begin
      pv = (i > 0) ? lvl[i-1] : 1'b0;
      if (lvl[i] && !pv) begin
        rs.push_back(i + 3);
        push(K_RISE, i + 3, 1);
        push(K_RISE3, i + 4, 1);
      end
      if (!lvl[i] && pv) push(K_FALL, i + 3, 1);
    end
    for (int j = 0; j <= rs.size(); j++) begin
      nxt = (j < rs.size()) ? rs[j] : (1 << 20);
      if ((st == 1 || st == 2) && nxt > last + LIM) begin
        if (st == 2) push(K_LOCK, last + LIM + 1, 0);
        if (last + LIM + 1 < MAXL) setv[last + LIM + 1] = 1;
        st = 3;
      end
      if (j == rs.size()) break;
      gap = nxt - last;
      ok = gap >= EXP - TOL && gap <= EXP + TOL;
      if (st == 0 || st == 3) begin
        st = 1;
        g = 0;
      end else begin
        push(K_PER, nxt + 1, gap > 15 ? 15 : gap);
        push(K_PER3, nxt + 2, gap > 15 ? 15 : gap);
        if (st == 1) begin
          g = ok ? g + 1 : 0;
          if (g == LCK) begin
            st = 2;
            push(K_LOCK, nxt + 1, 1);
          end
        end else if (!ok) begin
          st = 3;
          push(K_LOCK, nxt + 1, 0);
          if (nxt + 1 < MAXL) setv[nxt + 1] = 1;
        end
      end
      last = nxt;
    end
    for (int t = 0; t < cur_len; t++) begin
      nl = setv[t] ? 1 : ((t > 0 && clrs[t-1]) ? 0 : l);
      if (nl != l) push(K_LOST, t, nl);
      l = nl;
    end
  endtask

  task automatic build(input int lead);
    int h;
    for (int i = 0; i < MAXL; i++) begin
      lvl[i] = 0;
      clrs[i] = 0;
    end
    tpl = lead;
    foreach (plan[j]) begin
      h = $urandom_range(1, plan[j] - 1);
      for (int i = 0; i < h; i++) lvl[tpl + i] = 1;
      tpl += plan[j];
    end
  endtask

  task automatic check_zero(input string nm);
    n_cmp++;
    if ({rise, fall, period_vld, period, locked, lost, rise3, fall3, pv3, period3, locked3, lost3} !== '0) begin
      n_bad++;
      $display("FAIL %s: outputs %b/%b/%b/%0d/%b/%b s3 %b/%b/%b/%0d/%b/%b, required all 0", nm,
               rise, fall, period_vld, period, locked, lost, rise3, fall3, pv3, period3, locked3, lost3);
    end
  endtask

  task automatic end_phase();
    #1;
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (q[k].size() != 0) begin
        n_bad++;
        $display("FAIL %s leftover: %0d pending, required 0", names[k], q[k].size());
        q[k].delete();
      end
    end
    n_cmp++;
    if (locked !== exp_lock[0] || lost !== exp_lost[0]) begin
      n_bad++;
      $display("FAIL end_state: locked %b lost %b, required %0d %0d", locked, lost, exp_lock, exp_lost);
    end
    rst_n = 0;
    mon_en = 0;
    #1 check_zero("async_reset");
    sclk = 0;
    clr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    prev_lock = 0;
    prev_lost = 0;
    rst_n = 1;
    mon_en = 1;
  endtask

  task automatic run(input int len);
    cur_len = len;
    t0 = cyc;
    model();
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      sclk = lvl[i];
      clr = clrs[i];
    end
    end_phase();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    rst_n = 1;
    mon_en = 1;
    plan.delete(); repeat (10) plan.push_back(8);
    build(2 + $urandom_range(0, 3)); run(tpl + 2);
    plan.delete(); repeat (6) plan.push_back(8);
    build(2 + $urandom_range(0, 3)); clrs[tpl + 12] = 1; run(tpl + 20);
    plan.delete(); repeat (6) plan.push_back(12);
    build(2 + $urandom_range(0, 3)); run(tpl + 4);
    plan = '{7, 9, 7, 9, 10, 8, 8, 8, 8, 8, 8};
    build(2 + $urandom_range(0, 3)); run(tpl + 2);
    // clr lands in the timeout cycle so the loss and the clear collide.
    plan.delete(); repeat (6) plan.push_back(8);
    build(2 + $urandom_range(0, 3)); clrs[tpl + 5] = 1; clrs[tpl + 14] = 1; run(tpl + 20);
    plan.delete(); repeat (7) plan.push_back(8);
    build(2 + $urandom_range(0, 3)); run(tpl);
    repeat (4) begin
      plan.delete();
      repeat (12) plan.push_back($urandom_range(0, 2) == 0 ? $urandom_range(6, 11) : $urandom_range(7, 9));
      build(2 + $urandom_range(0, 3));
      for (int i = 0; i < tpl; i++) clrs[i] = ($urandom_range(0, 19) == 0);
      run(tpl + $urandom_range(0, 14));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
